// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and opcode constants for the fetch stage
package instr_fetch_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_JMP  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef logic [15:0] instr_word_t;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

    // Opcode field of an instruction word
    function automatic logic [3:0] opcode_of(input instr_word_t w);
        return w[15:12];
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter with load-over-increment priority
module instr_fetch_pc_reg #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] pc
);

    // PC update: a redirect load wins over sequential increment; increment wraps at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 8'd1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch/issue stage ahead of the datapath
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [7:0]  br_target,
    input  logic        resume,
    output logic [3:0]  opcode,
    output logic [11:0] operands,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Last WAIT cycle allowed without data; the miss on this cycle ends the fetch
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    fetch_state_t  state;
    fetch_state_t  next_state;
    instr_word_t   ir;
    logic [CW-1:0] wait_cnt;

    logic pc_inc;
    logic pc_load;
    logic ir_load;
    logic cnt_clr;
    logic cnt_inc;
    logic err_set;
    logic err_clr;

    instr_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (br_target),
        .pc       (pc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state = state;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            BOOT: begin
                next_state = FETCH;
            end
            FETCH: begin
                cnt_clr    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (imem_valid) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = ISSUE;
                end else begin
                    cnt_inc = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        err_set    = 1'b1;
                        next_state = HALTED;
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (opcode_of(ir) == OP_HALT) begin
                        next_state = HALTED;
                    end else if (br_taken) begin
                        pc_load    = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = FETCH;
                    end
                end
            end
            HALTED: begin
                if (resume) begin
                    err_clr    = 1'b1;
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // Instruction register, loaded only when memory returns data in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 16'h0000;
        end else if (ir_load) begin
            ir <= imem_rdata;
        end
    end

    // Cycles spent in WAIT without a data return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (cnt_clr) begin
            wait_cnt <= '0;
        end else if (cnt_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky fetch timeout flag, cleared only on leaving HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end else if (err_clr) begin
            fetch_err <= 1'b0;
        end
    end

    assign imem_req    = (state == FETCH) || (state == WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALTED);
    assign opcode      = ir[15:12];
    assign operands    = ir[11:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        resume = 1'b0;
    logic [3:0]  opcode;
    logic [11:0] operands;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // Expected {opcode, operands, pc} per issued instruction
    logic [23:0] sb_q[$];

    instr_fetch #(
        .RESET_PC (8'h00),
        .TIMEOUT  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .resume      (resume),
        .opcode      (opcode),
        .operands    (operands),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    imem_req,    32'h0);
        check({tag, "_ivalid"}, instr_valid, 32'h0);
        check({tag, "_pc"},     pc,          32'h00);
        check({tag, "_addr"},   imem_addr,   32'h00);
        check({tag, "_opc"},    opcode,      32'h0);
        check({tag, "_opnd"},   operands,    32'h000);
        check({tag, "_halted"}, halted,      32'h0);
        check({tag, "_err"},    fetch_err,   32'h0);
    endtask

    task automatic pop_check(input string tag);
        logic [23:0] e;
        check({tag, "_ivalid"}, instr_valid, 32'h1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_opc"},  opcode,   {28'h0, e[23:20]});
            check({tag, "_opnd"}, operands, {20'h0, e[19:8]});
            check({tag, "_pc"},   pc,       {24'h0, e[7:0]});
        end
    endtask

    // Wait for a request, return word one cycle after it, check the issued result
    task automatic fetch_one(input string tag, input logic [15:0] word,
                             input bit br_in_wait, input logic [7:0] exp_addr);
        int          n;
        logic [7:0]  nxt;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"},  imem_req,  32'h1);
        check({tag, "_addr"}, imem_addr, {24'h0, exp_addr});
        nxt = exp_addr + 8'd1;
        sb_q.push_back({word[15:12], word[11:0], nxt});
        step();
        if (br_in_wait) begin
            br_taken  = 1'b1;
            br_target = 8'h99;
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        br_taken   = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        // Reset values
        #2;
        check_reset_outputs("rst");
        step();
        rst_n = 1'b1;
        step();
        check("boot_to_fetch_req", imem_req, 32'h1);

        // First fetch: one-cycle memory latency
        fetch_one("first", 16'h1234, 1'b0, 8'h00);

        // Stall holds the instruction for 4 cycles
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_ivalid", instr_valid, 32'h1);
            check("stall_opnd",   operands,    32'h234);
            check("stall_pc",     pc,          32'h01);
            check("stall_req",    imem_req,    32'h0);
        end
        stall = 1'b0;
        step();
        check("post_stall_req",  imem_req,  32'h1);
        check("post_stall_addr", imem_addr, 32'h01);

        // br_taken during WAIT is ignored
        fetch_one("brwait", 16'h2111, 1'b1, 8'h01);

        // Taken branch on handshake
        br_taken  = 1'b1;
        br_target = 8'h40;
        step();
        br_taken  = 1'b0;
        check("branch_req",  imem_req,  32'h1);
        check("branch_addr", imem_addr, 32'h40);
        fetch_one("target", 16'h3456, 1'b0, 8'h40);

        // PC wrap from FF to 00
        br_taken  = 1'b1;
        br_target = 8'hFF;
        step();
        br_taken  = 1'b0;
        fetch_one("wrap", 16'h4777, 1'b0, 8'hFF);

        // HALT word; a branch on the same handshake is ignored
        fetch_one("halt", 16'hF000, 1'b0, 8'h00);
        br_taken  = 1'b1;
        br_target = 8'h77;
        step();
        br_taken  = 1'b0;
        check("halt_halted", halted,      32'h1);
        check("halt_req",    imem_req,    32'h0);
        check("halt_ivalid", instr_valid, 32'h0);
        step();
        step();
        check("halt_hold", halted, 32'h1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", halted,    32'h0);
        check("resume_req",    imem_req,  32'h1);
        check("resume_addr",   imem_addr, 32'h01);

        // Timeout with memory silent
        step();
        check("to_wait1_req", imem_req, 32'h1);
        step();
        step();
        check("to_wait3_halted", halted,    32'h0);
        check("to_wait3_err",    fetch_err, 32'h0);
        step();
        check("to_halted", halted,    32'h1);
        check("to_err",    fetch_err, 32'h1);
        check("to_pc",     pc,        32'h01);
        check("to_req",    imem_req,  32'h0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("to_resume_err", fetch_err, 32'h0);
        check("to_resume_req", imem_req,  32'h1);

        // Asynchronous reset in the middle of WAIT
        step();
        check("pre_rst_wait_req", imem_req, 32'h1);
        imem_valid = 1'b1;
        imem_rdata = 16'hEEEE;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst_n = 1'b1;

        // Stale imem_valid through BOOT and FETCH is ignored
        step();
        check("late_fetch_req",    imem_req,    32'h1);
        check("late_fetch_ivalid", instr_valid, 32'h0);
        step();
        check("late_wait_ivalid", instr_valid, 32'h0);
        check("late_wait_req",    imem_req,    32'h1);
        imem_rdata = 16'h5ABC;
        sb_q.push_back({4'h5, 12'hABC, 8'h01});
        step();
        imem_valid = 1'b0;
        pop_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
